// File: rtl/vga_grid_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_grid_display                                                         |
// | VGA raster engine with GRID_N x GRID_N tile decode and a tear-free       |
// | double-registered board buffer. Optional macro: VGA_GRID_BORDER_EN.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vga_grid_display #(
  parameter int          Thw        = 136,
  parameter int          Thbp       = 160,
  parameter int          Thfp       = 24,
  parameter int          Thdw       = 1024,
  parameter int          Tvw        = 6,
  parameter int          Tvbp       = 29,
  parameter int          Tvfp       = 3,
  parameter int          Tvdw       = 768,
  parameter bit          Hsync_pol  = 1'b1,
  parameter bit          Vsync_pol  = 1'b1,
  parameter int          GRID_N     = 4,
  parameter int          CELL_BITS  = 4,
  parameter int          TILE       = 150,
  parameter int          GAP        = 30,
  parameter int          H_ORG      = 150,
  parameter int          V_ORG      = 30,
  parameter int          XYW        = 8,
  parameter int          TILE_LAT   = 1,
  parameter logic [11:0] BG_RGB     = 12'h000,
  parameter int          BORDER_W   = 4,
  parameter logic [11:0] BORDER_RGB = 12'hFFF
) (
  input  logic                                 clk_65,
  input  logic                                 rst,
  input  logic [GRID_N*GRID_N*CELL_BITS-1:0]   board_in,
  input  logic                                 board_valid,
  output logic                                 board_ready,
  output logic                                 tile_req,
  output logic [CELL_BITS-1:0]                 tile_state,
  output logic [XYW-1:0]                       tile_x,
  output logic [XYW-1:0]                       tile_y,
  input  logic [11:0]                          tile_rgb,
  output logic                                 frame_start,
  output logic                                 vga_hs,
  output logic                                 vga_vs,
  output logic [3:0]                           vga_r,
  output logic [3:0]                           vga_g,
  output logic [3:0]                           vga_b
);

  localparam int c_thp     = Thw + Thbp + Thdw + Thfp;
  localparam int c_tvp     = Tvw + Tvbp + Tvdw + Tvfp;
  localparam int c_h_start = Thw + Thbp;
  localparam int c_h_end   = Thw + Thbp + Thdw;
  localparam int c_v_start = Tvw + Tvbp;
  localparam int c_v_end   = Tvw + Tvbp + Tvdw;
  localparam int c_pitch   = TILE + GAP;
  localparam int c_bw      = GRID_N * GRID_N * CELL_BITS;

  localparam logic [11:0] c_h_last = 12'(c_thp - 1);
  localparam logic [11:0] c_v_last = 12'(c_tvp - 1);

`ifdef VGA_GRID_BORDER_EN
  localparam int c_flw = 5;
`else
  localparam int c_flw = 4;
`endif

  // Flag bit positions inside the delay line
  localparam int c_f_tile = 0;
  localparam int c_f_act  = 1;
  localparam int c_f_vs   = 2;
  localparam int c_f_hs   = 3;

  logic [11:0]          r_hcnt;
  logic [11:0]          r_vcnt;
  logic [31:0]          w_h32;
  logic [31:0]          w_v32;
  logic                 w_hs_on;
  logic                 w_vs_on;
  logic                 w_act;
  logic                 w_frame_end;
  logic [11:0]          w_px;
  logic [11:0]          w_py;
  logic [31:0]          w_px32;
  logic [31:0]          w_py32;
  logic [GRID_N-1:0]    w_col_hit;
  logic [GRID_N-1:0]    w_row_hit;
  logic [11:0]          w_col_org;
  logic [11:0]          w_row_org;
  logic                 w_in_tile;
  logic [CELL_BITS-1:0] w_state;
  logic [XYW-1:0]       w_tx;
  logic [XYW-1:0]       w_ty;

  logic [c_bw-1:0]      r_pending;
  logic [c_bw-1:0]      r_active;
  logic                 r_pend_full;

  logic                 r_s1_hs;
  logic                 r_s1_vs;
  logic                 r_s1_act;
  logic [c_flw-1:0]     w_s1_flags;
  logic [c_flw-1:0]     r_dly [TILE_LAT];
  logic [c_flw-1:0]     w_d;
  logic [11:0]          w_tile_pix;
  logic [11:0]          r_rgb;

  // ---------------- Stage 0: raster counters ----------------
  always_ff @(posedge clk_65) begin
    if (rst) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (r_hcnt == c_h_last) begin
      r_hcnt <= '0;
      r_vcnt <= (r_vcnt == c_v_last) ? 12'd0 : r_vcnt + 12'd1;
    end else begin
      r_hcnt <= r_hcnt + 12'd1;
    end
  end

  assign w_h32       = {20'd0, r_hcnt};
  assign w_v32       = {20'd0, r_vcnt};
  assign w_hs_on     = (w_h32 < Thw);
  assign w_vs_on     = (w_v32 < Tvw);
  assign w_act       = (w_h32 >= c_h_start) && (w_h32 < c_h_end) &&
                       (w_v32 >= c_v_start) && (w_v32 < c_v_end);
  assign w_frame_end = (r_hcnt == c_h_last) && (r_vcnt == c_v_last);

  // Outside the active area these wrap; every consumer is gated by w_act.
  assign w_px   = r_hcnt - 12'(c_h_start);
  assign w_py   = r_vcnt - 12'(c_v_start);
  assign w_px32 = {20'd0, w_px};
  assign w_py32 = {20'd0, w_py};

  // ---------------- Tile decode: one comparator pair per column / row ----------------
  for (genvar gc = 0; gc < GRID_N; gc++) begin : g_col
    localparam int c_lo = H_ORG + gc * c_pitch;
    assign w_col_hit[gc] = (w_px32 >= c_lo) && (w_px32 < c_lo + TILE);
  end

  for (genvar gr = 0; gr < GRID_N; gr++) begin : g_row
    localparam int c_lo = V_ORG + gr * c_pitch;
    assign w_row_hit[gr] = (w_py32 >= c_lo) && (w_py32 < c_lo + TILE);
  end

  always_comb begin
    w_col_org = '0;
    w_row_org = '0;
    w_in_tile = 1'b0;
    w_state   = '0;
    for (int c = 0; c < GRID_N; c++) begin
      if (w_col_hit[c]) w_col_org = 12'(H_ORG + c * c_pitch);
    end
    for (int r = 0; r < GRID_N; r++) begin
      if (w_row_hit[r]) w_row_org = 12'(V_ORG + r * c_pitch);
    end
    for (int r = 0; r < GRID_N; r++) begin
      for (int c = 0; c < GRID_N; c++) begin
        if (w_act && w_row_hit[r] && w_col_hit[c]) begin
          w_in_tile = 1'b1;
          w_state   = r_active[(GRID_N*GRID_N - (r*GRID_N + c))*CELL_BITS-1 -: CELL_BITS];
        end
      end
    end
  end

  assign w_tx = XYW'(w_px - w_col_org);
  assign w_ty = XYW'(w_py - w_row_org);

  // ---------------- Board buffer: pending slot and frame-synchronous swap ----------------
  always_ff @(posedge clk_65) begin
    if (rst) begin
      r_pending   <= '0;
      r_active    <= '0;
      r_pend_full <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (w_frame_end && r_pend_full) begin
        r_active    <= r_pending;
        r_pend_full <= 1'b0;
        frame_start <= 1'b1;
      end else if (board_valid && !r_pend_full) begin
        r_pending   <= board_in;
        r_pend_full <= 1'b1;
      end
    end
  end

  assign board_ready = ~r_pend_full;

  // ---------------- Stage 1: registered decode ----------------
  always_ff @(posedge clk_65) begin
    if (rst) begin
      tile_req   <= 1'b0;
      tile_state <= '0;
      tile_x     <= '0;
      tile_y     <= '0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_s1_act   <= 1'b0;
    end else begin
      tile_req   <= w_in_tile;
      tile_state <= w_in_tile ? w_state : '0;
      tile_x     <= w_in_tile ? w_tx : '0;
      tile_y     <= w_in_tile ? w_ty : '0;
      r_s1_hs    <= w_hs_on;
      r_s1_vs    <= w_vs_on;
      r_s1_act   <= w_act;
    end
  end

`ifdef VGA_GRID_BORDER_EN
  logic r_s1_border;

  always_ff @(posedge clk_65) begin
    if (rst) begin
      r_s1_border <= 1'b0;
    end else begin
      r_s1_border <= w_in_tile &&
                     ((32'(w_tx) < BORDER_W) || (32'(w_tx) >= TILE - BORDER_W) ||
                      (32'(w_ty) < BORDER_W) || (32'(w_ty) >= TILE - BORDER_W));
    end
  end

  assign w_s1_flags = {r_s1_border, r_s1_hs, r_s1_vs, r_s1_act, tile_req};
  assign w_tile_pix = w_d[4] ? BORDER_RGB : tile_rgb;
`else
  logic w_unused_border;

  assign w_unused_border = ^{BORDER_RGB, 32'(BORDER_W)};
  assign w_s1_flags      = {r_s1_hs, r_s1_vs, r_s1_act, tile_req};
  assign w_tile_pix      = tile_rgb;
`endif

  // ---------------- Stages 2..1+TILE_LAT: align flags with renderer ----------------
  always_ff @(posedge clk_65) begin
    if (rst) begin
      for (int i = 0; i < TILE_LAT; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= w_s1_flags;
      for (int i = 1; i < TILE_LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign w_d = r_dly[TILE_LAT-1];

  // ---------------- Final stage: output mux ----------------
  always_ff @(posedge clk_65) begin
    if (rst) begin
      vga_hs <= Hsync_pol;
      vga_vs <= Vsync_pol;
      r_rgb  <= '0;
    end else begin
      vga_hs <= w_d[c_f_hs] ^ Hsync_pol;
      vga_vs <= w_d[c_f_vs] ^ Vsync_pol;
      if (w_d[c_f_tile])     r_rgb <= w_tile_pix;
      else if (w_d[c_f_act]) r_rgb <= BG_RGB;
      else                   r_rgb <= '0;
    end
  end

  assign {vga_r, vga_g, vga_b} = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_grid_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_grid_display                                                      |
// | Scoreboard bench for vga_grid_display on a reduced video mode.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vga_grid_display;

  localparam int HW = 8, HBP = 6, HDW = 40, HFP = 4;
  localparam int HP = HW + HBP + HDW + HFP;
  localparam int VW = 2, VBP = 3, VDW = 30, VFP = 2;
  localparam int VP = VW + VBP + VDW + VFP;
  localparam int N = 4, CB = 4, TL = 4, GP = 2, HO = 3, VO = 2, XW = 3, LAT = 3;
  localparam logic [11:0] BG = 12'h5A3;
  localparam int PIPE = 2 + LAT;

  logic              clk_65 = 1'b0;
  logic              rst = 1'b1;
  logic [N*N*CB-1:0] board_in = '0;
  logic              board_valid = 1'b0;
  logic              board_ready;
  logic              tile_req;
  logic [CB-1:0]     tile_state;
  logic [XW-1:0]     tile_x;
  logic [XW-1:0]     tile_y;
  logic [11:0]       tile_rgb;
  logic              frame_start;
  logic              vga_hs, vga_vs;
  logic [3:0]        vga_r, vga_g, vga_b;
  logic [13:0]       pins;

  logic [11:0]       r_stub [LAT];

  int                vectors = 0;
  int                miscompares = 0;

  // Bench model state
  int                m_h, m_v;
  logic [63:0]       m_active, m_pending;
  bit                m_full, m_fs, m_req;
  logic [3:0]        m_st;
  logic [2:0]        m_tx, m_ty;
  logic [13:0]       sb[$];
  logic [13:0]       sb_exp;

  vga_grid_display #(
    .Thw(HW), .Thbp(HBP), .Thfp(HFP), .Thdw(HDW),
    .Tvw(VW), .Tvbp(VBP), .Tvfp(VFP), .Tvdw(VDW),
    .Hsync_pol(1'b1), .Vsync_pol(1'b1),
    .GRID_N(N), .CELL_BITS(CB), .TILE(TL), .GAP(GP),
    .H_ORG(HO), .V_ORG(VO), .XYW(XW), .TILE_LAT(LAT), .BG_RGB(BG)
  ) dut (
    .clk_65(clk_65), .rst(rst),
    .board_in(board_in), .board_valid(board_valid), .board_ready(board_ready),
    .tile_req(tile_req), .tile_state(tile_state), .tile_x(tile_x), .tile_y(tile_y),
    .tile_rgb(tile_rgb), .frame_start(frame_start),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk_65 = ~clk_65;

  assign pins = {vga_hs, vga_vs, vga_r, vga_g, vga_b};

  // Fixed-latency renderer stub: echoes the request fields as a colour
  always @(posedge clk_65) begin
    r_stub[0] <= {tile_state, 1'b0, tile_x, 1'b0, tile_y};
    for (int i = 1; i < LAT; i++) r_stub[i] <= r_stub[i-1];
  end
  assign tile_rgb = r_stub[LAT-1];

  function automatic void model_tile(input int h, input int v, input logic [63:0] act,
                                     output bit hit, output logic [3:0] st,
                                     output logic [2:0] tx, output logic [2:0] ty);
    int px, py, c, r, xr, yr;
    hit = 1'b0; st = '0; tx = '0; ty = '0;
    if (h >= HW + HBP && h < HW + HBP + HDW && v >= VW + VBP && v < VW + VBP + VDW) begin
      px = h - (HW + HBP);
      py = v - (VW + VBP);
      if (px >= HO && py >= VO) begin
        c  = (px - HO) / (TL + GP);
        xr = (px - HO) % (TL + GP);
        r  = (py - VO) / (TL + GP);
        yr = (py - VO) % (TL + GP);
        if (c < N && r < N && xr < TL && yr < TL) begin
          hit = 1'b1;
          tx  = 3'(xr);
          ty  = 3'(yr);
          st  = 4'(act >> ((N*N - 1 - (r*N + c)) * CB));
        end
      end
    end
  endfunction

  function automatic logic [13:0] model_pins(input int h, input int v, input logic [63:0] act);
    bit hit;
    logic [3:0] st;
    logic [2:0] tx, ty;
    logic [11:0] rgb;
    model_tile(h, v, act, hit, st, tx, ty);
    if (hit) rgb = {st, 1'b0, tx, 1'b0, ty};
    else if (h >= HW + HBP && h < HW + HBP + HDW && v >= VW + VBP && v < VW + VBP + VDW) rgb = BG;
    else rgb = 12'h000;
    return {(h >= HW), (v >= VW), rgb};
  endfunction

  // Advance one clock; update the model and expose the expected pins for the new cycle.
  task automatic tick();
    bit hit, acc, swp;
    logic [3:0] st;
    logic [2:0] tx, ty;
    logic [63:0] din;
    model_tile(m_h, m_v, m_active, hit, st, tx, ty);
    acc = board_valid && !m_full;
    din = board_in;
    swp = (m_h == HP - 1) && (m_v == VP - 1) && m_full;
    @(posedge clk_65); #1;
    m_req = hit; m_st = st; m_tx = tx; m_ty = ty;
    m_fs = swp;
    if (swp) begin
      m_active = m_pending;
      m_full   = 1'b0;
    end else if (acc) begin
      m_pending = din;
      m_full    = 1'b1;
    end
    m_h++;
    if (m_h == HP) begin
      m_h = 0;
      m_v = (m_v == VP - 1) ? 0 : m_v + 1;
    end
    sb.push_back(model_pins(m_h, m_v, m_active));
    sb_exp = sb.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    board_valid = 1'b0;
    repeat (3) @(posedge clk_65);
    #1;
    vectors++; if (vga_hs !== 1'b1) begin miscompares++; $display("FAIL reset_hs got %b want 1", vga_hs); end
    vectors++; if (vga_vs !== 1'b1) begin miscompares++; $display("FAIL reset_vs got %b want 1", vga_vs); end
    vectors++; if (pins[11:0] !== 12'h000) begin miscompares++; $display("FAIL reset_rgb got %h want 000", pins[11:0]); end
    vectors++; if (board_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", board_ready); end
    vectors++; if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_fs got %b want 0", frame_start); end
    vectors++; if (tile_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %b want 0", tile_req); end
    rst = 1'b0;
    m_h = 0; m_v = 0; m_active = '0; m_pending = '0;
    m_full = 1'b0; m_fs = 1'b0; m_req = 1'b0; m_st = '0; m_tx = '0; m_ty = '0;
    sb.delete();
    repeat (PIPE) sb.push_back(14'h3000);
    sb.push_back(model_pins(0, 0, '0));
    sb_exp = sb.pop_front();
    vectors++; if (pins !== sb_exp) begin miscompares++; $display("FAIL reset_pins got %h want %h", pins, sb_exp); end
  endtask

  task automatic test_latency();
    int hs_at, rgb_at;
    hs_at = -1; rgb_at = -1;
    test_reset();
    for (int i = 1; i <= 400; i++) begin
      tick();
      vectors++; if (pins !== sb_exp) begin miscompares++; $display("FAIL lat_pins cyc %0d got %h want %h", i, pins, sb_exp); end
      if (hs_at < 0 && vga_hs === 1'b0) hs_at = i;
      if (rgb_at < 0 && pins[11:0] !== 12'h000) rgb_at = i;
    end
    vectors++; if (hs_at != PIPE) begin miscompares++; $display("FAIL lat_hs got %0d want %0d", hs_at, PIPE); end
    vectors++;
    if (rgb_at != (VW + VBP) * HP + HW + HBP + PIPE) begin
      miscompares++; $display("FAIL lat_rgb got %0d want %0d", rgb_at, (VW + VBP) * HP + HW + HBP + PIPE);
    end
  endtask

  task automatic test_sync_timing();
    int hs_lo, vs_lo;
    hs_lo = 0; vs_lo = 0;
    for (int i = 0; i < HP * VP; i++) begin
      tick();
      vectors++; if (pins !== sb_exp) begin miscompares++; $display("FAIL sync_pins cyc %0d got %h want %h", i, pins, sb_exp); end
      if (vga_hs === 1'b0) hs_lo++;
      if (vga_vs === 1'b0) vs_lo++;
    end
    vectors++; if (hs_lo != HW * VP) begin miscompares++; $display("FAIL sync_hs_low got %0d want %0d", hs_lo, HW * VP); end
    vectors++; if (vs_lo != VW * HP) begin miscompares++; $display("FAIL sync_vs_low got %0d want %0d", vs_lo, VW * HP); end
  endtask

  task automatic test_decode();
    board_in = 64'hFEDC_BA98_7654_3210;
    board_valid = 1'b1;
    tick();
    board_valid = 1'b0;
    vectors++; if (board_ready !== 1'b0) begin miscompares++; $display("FAIL dec_ready got %b want 0", board_ready); end
    for (int i = 0; i < 2 * HP * VP; i++) begin
      tick();
      vectors++; if (pins !== sb_exp) begin miscompares++; $display("FAIL dec_pins cyc %0d got %h want %h", i, pins, sb_exp); end
      vectors++;
      if ({tile_req, tile_state, tile_x, tile_y} !== {m_req, m_st, m_tx, m_ty}) begin
        miscompares++;
        $display("FAIL dec_tile cyc %0d got %b/%h/%0d/%0d want %b/%h/%0d/%0d", i,
                 tile_req, tile_state, tile_x, tile_y, m_req, m_st, m_tx, m_ty);
      end
      vectors++;
      if ({frame_start, board_ready} !== {m_fs, !m_full}) begin
        miscompares++; $display("FAIL dec_ctl cyc %0d got %b%b want %b%b", i, frame_start, board_ready, m_fs, !m_full);
      end
    end
  endtask

  task automatic test_tear_free();
    int fs_cnt;
    fs_cnt = 0;
    for (int i = 0; i < HP * VP && m_v != VP / 2; i++) begin
      tick();
      vectors++; if (pins !== sb_exp) begin miscompares++; $display("FAIL tear_pre got %h want %h", pins, sb_exp); end
    end
    board_in = 64'h1;
    board_valid = 1'b1;
    tick();
    board_valid = 1'b0;
    vectors++; if (board_ready !== 1'b0) begin miscompares++; $display("FAIL tear_ready got %b want 0", board_ready); end
    for (int i = 0; i < 2 * HP * VP; i++) begin
      tick();
      vectors++; if (pins !== sb_exp) begin miscompares++; $display("FAIL tear_pins cyc %0d got %h want %h", i, pins, sb_exp); end
      vectors++;
      if ({frame_start, board_ready} !== {m_fs, !m_full}) begin
        miscompares++; $display("FAIL tear_ctl cyc %0d got %b%b want %b%b", i, frame_start, board_ready, m_fs, !m_full);
      end
      if (frame_start === 1'b1) fs_cnt++;
    end
    vectors++; if (fs_cnt != 1) begin miscompares++; $display("FAIL tear_fs_count got %0d want 1", fs_cnt); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ok = 1'b0;
    board_in = 64'hA5A5_5A5A_C3C3_3C3C;
    board_valid = 1'b1;
    tick();
    board_in = 64'h0123_4567_89AB_CDEF;
    for (int i = 0; i < HP * VP + 10; i++) begin
      tick();
      vectors++; if (pins !== sb_exp) begin miscompares++; $display("FAIL bp_pins cyc %0d got %h want %h", i, pins, sb_exp); end
      vectors++; if (board_ready !== !m_full) begin miscompares++; $display("FAIL bp_ready cyc %0d got %b want %b", i, board_ready, !m_full); end
      if (board_ready === 1'b1) begin ok = 1'b1; break; end
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL bp_wait got timeout want board_ready"); end
    tick();
    board_valid = 1'b0;
    vectors++; if (board_ready !== 1'b0) begin miscompares++; $display("FAIL bp_accept got %b want 0", board_ready); end
    for (int i = 0; i < 2 * HP * VP; i++) begin
      tick();
      vectors++; if (pins !== sb_exp) begin miscompares++; $display("FAIL bp_run cyc %0d got %h want %h", i, pins, sb_exp); end
      vectors++;
      if ({frame_start, board_ready} !== {m_fs, !m_full}) begin
        miscompares++; $display("FAIL bp_ctl cyc %0d got %b%b want %b%b", i, frame_start, board_ready, m_fs, !m_full);
      end
    end
    // Reset with a full pending slot: the pending board must be lost
    board_in = 64'hFFFF_FFFF_FFFF_FFFF;
    board_valid = 1'b1;
    tick();
    board_valid = 1'b0;
    vectors++; if (board_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full got %b want 0", board_ready); end
    test_reset();
    for (int i = 0; i < HP * VP + PIPE; i++) begin
      tick();
      vectors++; if (pins !== sb_exp) begin miscompares++; $display("FAIL bp_rst_pins cyc %0d got %h want %h", i, pins, sb_exp); end
      vectors++;
      if ({frame_start, board_ready, tile_state} !== {m_fs, !m_full, m_st}) begin
        miscompares++;
        $display("FAIL bp_rst_ctl cyc %0d got %b%b%h want %b%b%h", i, frame_start, board_ready, tile_state, m_fs, !m_full, m_st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sync_timing();
    test_decode();
    test_tear_free();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
`default_nettype wire
